// File: rtl/mul_share_arb.sv
// Round-robin arbiter that time-shares one serial 2W-bit-product multiplier among NREQ requesters.
// Optional RUN-phase watchdog is compiled in with `define MUL_ARB_TIMEOUT_EN.
module mul_share_arb #(
    parameter int NREQ    = 4,
    parameter int W       = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     i_req,
    input  logic [NREQ*W-1:0]   i_opa,
    input  logic [NREQ*W-1:0]   i_opb,
    output logic [NREQ-1:0]     o_gnt,
    output logic [NREQ-1:0]     o_done,
    output logic [2*W-1:0]      o_result,
    output logic                o_busy,
    output logic                o_mul_rst_n,
    output logic [W-1:0]        o_mul_ina,
    output logic [W-1:0]        o_mul_inb,
    input  logic                i_mul_ready_n,
    input  logic [2*W-1:0]      i_mul_result,
    output logic                o_err
);

    localparam int PW = $clog2(NREQ);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_param_check
        $error("mul_share_arb: NREQ must be 2..8 and TIMEOUT must be positive");
    end

    state_t             r_state;
    state_t             w_next;
    logic [PW-1:0]      r_ptr;
    logic [PW-1:0]      r_owner;
    logic [NREQ-1:0]    r_gnt;
    logic [W-1:0]       r_ina;
    logic [W-1:0]       r_inb;
    logic [2*W-1:0]     r_result;
    logic               r_first;

    logic               w_found;
    logic [PW-1:0]      w_win;
    logic [PW:0]        w_sum;
    logic               w_rdy;
    logic               w_timeout;

    // Rotating priority search: first request at or after the pointer, wrapping at NREQ.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (PW+1)'(k);
            if (w_sum >= (PW+1)'(NREQ)) begin
                w_sum = w_sum - (PW+1)'(NREQ);
            end
            if (!w_found && i_req[w_sum[PW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_sum[PW-1:0];
            end
        end
    end

    // The ready flag seen on the first RUN cycle is left over from the previous operation.
    assign w_rdy = (r_state == S_RUN) && !r_first && !i_mul_ready_n;

`ifdef MUL_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0]      r_cnt;
    logic               r_err;

    assign w_timeout = (r_state == S_RUN) && !w_rdy && (r_cnt == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_err <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: r_cnt <= '0;
                S_RUN: begin
                    r_cnt <= r_cnt + 1'b1;
                    r_err <= w_timeout;
                end
                default: r_err <= 1'b0;
            endcase
        end
    end

    assign o_err = r_err;
`else
    assign w_timeout = 1'b0;
    assign o_err     = 1'b0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: w_next = S_RUN;
            S_RUN: begin
                if (w_rdy || w_timeout) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_ptr    <= '0;
            r_owner  <= '0;
            r_gnt    <= '0;
            r_ina    <= '0;
            r_inb    <= '0;
            r_result <= '0;
            r_first  <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_win;
                        r_gnt   <= NREQ'(1) << w_win;
                        r_ina   <= i_opa[w_win*W +: W];
                        r_inb   <= i_opb[w_win*W +: W];
                    end
                end
                S_LOAD: r_first <= 1'b1;
                S_RUN: begin
                    r_first <= 1'b0;
                    if (w_rdy) begin
                        r_result <= i_mul_result;
                    end else if (w_timeout) begin
                        r_result <= '0;
                    end
                end
                S_DONE: begin
                    r_gnt <= '0;
                    r_ptr <= (r_owner == PW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign o_gnt       = r_gnt;
    assign o_done      = (r_state == S_DONE) ? r_gnt : '0;
    assign o_busy      = (r_state != S_IDLE);
    assign o_mul_rst_n = (r_state == S_RUN);
    assign o_mul_ina   = r_ina;
    assign o_mul_inb   = r_inb;
    assign o_result    = r_result;

endmodule

// File: tb/tb_mul_share_arb.sv
// Bench for mul_share_arb: a transaction-level model plus a stub multiplier with a stale ready flag.
// Timeout scenario is exercised only when MUL_ARB_TIMEOUT_EN is defined.
module tb_mul_share_arb;

    localparam int NREQ = 4;
    localparam int W    = 32;
    localparam int TO   = 8;

    logic               clk;
    logic               rst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*W-1:0]  opa;
    logic [NREQ*W-1:0]  opb;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    done;
    logic [2*W-1:0]     result;
    logic               busy;
    logic               mulRstN;
    logic [W-1:0]       mulIna;
    logic [W-1:0]       mulInb;
    logic               readyN;
    logic [2*W-1:0]     prod;
    logic               err;

    int checkCount = 0;
    int passCount  = 0;
    bit checkEn    = 0;
    int curLat     = 3;
    int mulCnt     = 0;

    mul_share_arb #(.NREQ(NREQ), .W(W), .TIMEOUT(TO)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_req         (req),
        .i_opa         (opa),
        .i_opb         (opb),
        .o_gnt         (gnt),
        .o_done        (done),
        .o_result      (result),
        .o_busy        (busy),
        .o_mul_rst_n   (mulRstN),
        .o_mul_ina     (mulIna),
        .o_mul_inb     (mulInb),
        .i_mul_ready_n (readyN),
        .i_mul_result  (prod),
        .o_err         (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub multiplier: ready_n only refreshes while running, so it is stale on the first RUN cycle.
    initial readyN = 1'b1;
    always @(posedge clk) begin
        if (!mulRstN) begin
            mulCnt <= 0;
            prod   <= {32'b0, mulIna} * {32'b0, mulInb};
        end else begin
            mulCnt <= mulCnt + 1;
            readyN <= (mulCnt + 1 >= curLat) ? 1'b0 : 1'b1;
        end
    end

    bit          mActive = 0;
    bit          mTimedOut = 0;
    int          mT = 0;
    int          mDoneT = 0;
    int          mOwner = 0;
    int          mPtr = 0;
    logic [63:0] mProd = '0;
    logic [63:0] mResult = '0;
    logic [31:0] mIna = '0;
    logic [31:0] mInb = '0;
    bit          timeoutOn;

    initial begin
`ifdef MUL_ARB_TIMEOUT_EN
        timeoutOn = 1'b1;
`else
        timeoutOn = 1'b0;
`endif
    end

    // Model: an operation granted at IDLE-sample time 0 finishes at time 3+lat (or 2+TO on timeout).
    always @(posedge clk) begin
        if (!rst_n) begin
            mActive = 0;
            mPtr    = 0;
            mResult = '0;
            mIna    = '0;
            mInb    = '0;
        end else if (mActive) begin
            if (mT == mDoneT) begin
                mActive = 0;
                mPtr    = (mOwner + 1) % NREQ;
            end else begin
                mT = mT + 1;
                if (mT == mDoneT) mResult = mTimedOut ? 64'd0 : mProd;
            end
        end else if (req != 0) begin
            bit found;
            found = 0;
            for (int k = 0; k < NREQ; k++) begin
                int idx;
                idx = (mPtr + k) % NREQ;
                if (!found && req[idx]) begin
                    found  = 1;
                    mOwner = idx;
                end
            end
            mActive   = 1;
            mT        = 1;
            mIna      = opa[mOwner*W +: W];
            mInb      = opb[mOwner*W +: W];
            mProd     = {32'b0, mIna} * {32'b0, mInb};
            mTimedOut = timeoutOn && (curLat > TO - 1);
            mDoneT    = mTimedOut ? (2 + TO) : (3 + curLat);
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
        end
    endtask

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            logic [3:0] expGnt;
            bit         atDone;
            expGnt = mActive ? 4'(1 << mOwner) : 4'd0;
            atDone = mActive && (mT == mDoneT);
            checkOutput("gnt", 64'(gnt), 64'(expGnt));
            checkOutput("gnt_onehot0", 64'($onehot0(gnt)), 64'd1);
            checkOutput("done", 64'(done), atDone ? 64'(expGnt) : 64'd0);
            checkOutput("busy", 64'(busy), 64'(mActive));
            checkOutput("mul_rst_n", 64'(mulRstN), 64'(mActive && mT >= 2 && mT < mDoneT));
            checkOutput("result", result, mResult);
            checkOutput("err", 64'(err), 64'(atDone && mTimedOut));
            checkOutput("mul_ina", 64'(mulIna), 64'(mIna));
            checkOutput("mul_inb", 64'(mulInb), 64'(mInb));
        end
    end

    task automatic applyStimulus(input logic [NREQ-1:0] r);
        @(posedge clk);
        #2;
        req = r;
    endtask

    task automatic setOps(input int idx, input logic [31:0] a, input logic [31:0] b);
        opa[idx*W +: W] = a;
        opb[idx*W +: W] = b;
    endtask

    task automatic waitDone(output int owner, output logic [63:0] res, output logic errOut);
        bit got;
        got    = 0;
        owner  = -1;
        res    = '0;
        errOut = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (|done) begin
                got    = 1;
                res    = result;
                errOut = err;
                for (int i = 0; i < NREQ; i++) if (done[i]) owner = i;
            end
        end
        if (!got) begin
            checkCount++;
            $display("[TB] FAIL done_wait at %0t: no done within 60 cycles, expected one", $time);
        end
    endtask

    int          owner;
    logic [63:0] res;
    logic        errOut;
    int          expOrder [5] = '{0, 1, 2, 3, 0};
    logic [63:0] expRes   [5] = '{64'd39, 64'd85, 64'd133, 64'd253, 64'd39};

    initial begin
        rst_n = 1'b0;
        req   = '0;
        opa   = '0;
        opb   = '0;
        @(posedge clk);
        #2;
        checkEn = 1;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_gnt", 64'(gnt), 64'd0);
        checkOutput("reset_busy", 64'(busy), 64'd0);
        checkOutput("reset_result", result, 64'd0);
        checkOutput("reset_mul_rst_n", 64'(mulRstN), 64'd0);

        $display("[TB] single operation on requester 0");
        curLat = 3;
        setOps(0, 32'h0000FFFF, 32'h00010001);
        applyStimulus(4'b0001);
        waitDone(owner, res, errOut);
        checkOutput("t1_owner", 64'(owner), 64'd0);
        checkOutput("t1_result", res, 64'h00000000_FFFFFFFF);
        applyStimulus(4'b0000);
        @(negedge clk);
        checkOutput("t1_busy_after", 64'(busy), 64'd0);

        $display("[TB] max operands on requester 3");
        curLat = 2;
        setOps(3, 32'hFFFFFFFF, 32'hFFFFFFFF);
        applyStimulus(4'b1000);
        waitDone(owner, res, errOut);
        checkOutput("t5_owner", 64'(owner), 64'd3);
        checkOutput("t5_result", res, 64'hFFFFFFFE_00000001);
        applyStimulus(4'b0000);

        $display("[TB] round-robin with all requests held");
        setOps(0, 32'd3, 32'd13);
        setOps(1, 32'd5, 32'd17);
        setOps(2, 32'd7, 32'd19);
        setOps(3, 32'd11, 32'd23);
        applyStimulus(4'b1111);
        for (int i = 0; i < 5; i++) begin
            waitDone(owner, res, errOut);
            checkOutput("t2_owner", 64'(owner), 64'(expOrder[i]));
            checkOutput("t2_result", res, expRes[i]);
        end
        applyStimulus(4'b0000);

        $display("[TB] wrap and skip");
        curLat = 4;
        applyStimulus(4'b0100);
        waitDone(owner, res, errOut);
        checkOutput("t3_first_owner", 64'(owner), 64'd2);
        applyStimulus(4'b0101);
        waitDone(owner, res, errOut);
        checkOutput("t3_wrap_owner", 64'(owner), 64'd0);
        applyStimulus(4'b0100);
        waitDone(owner, res, errOut);
        checkOutput("t3_skip_owner", 64'(owner), 64'd2);
        checkOutput("t3_result", res, 64'd133);
        applyStimulus(4'b0000);

        $display("[TB] reset in the middle of an operation");
        curLat = 6;
        setOps(1, 32'h00001234, 32'h00000100);
        applyStimulus(4'b0001);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        req   = '0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("t4_gnt", 64'(gnt), 64'd0);
        checkOutput("t4_busy", 64'(busy), 64'd0);
        checkOutput("t4_result", result, 64'd0);
        curLat = 3;
        applyStimulus(4'b0010);
        waitDone(owner, res, errOut);
        checkOutput("t4_owner", 64'(owner), 64'd1);
        checkOutput("t4_new_result", res, 64'h00000000_00123400);
        applyStimulus(4'b0000);

`ifdef MUL_ARB_TIMEOUT_EN
        $display("[TB] multiplier never ready");
        curLat = 1000;
        setOps(0, 32'd5, 32'd5);
        applyStimulus(4'b0001);
        waitDone(owner, res, errOut);
        checkOutput("t6_owner", 64'(owner), 64'd0);
        checkOutput("t6_err", 64'(errOut), 64'd1);
        checkOutput("t6_result", res, 64'd0);
        applyStimulus(4'b0000);
        curLat = 2;
        applyStimulus(4'b0100);
        waitDone(owner, res, errOut);
        checkOutput("t6_next_owner", 64'(owner), 64'd2);
        checkOutput("t6_next_err", 64'(errOut), 64'd0);
        checkOutput("t6_next_result", res, 64'd133);
        applyStimulus(4'b0000);
`endif

        repeat (4) @(negedge clk);
        checkEn = 0;
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got no end, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
